add_mult_pipe: RTL and testbench
================================

Name: add_mult_pipe

Overview:
- Parametrised, elastic pipelined (a+b)*c datapath with an optional accumulate mode.
- Generalises the fixed-latency add/multiply pipelines with:
  - a configurable number of multiplier stages,
  - valid/ready handshaking with backpressure,
  - a sum tap aligned to each result.
- Sits between a streaming producer and consumer in the reconfigurable-computing datapath library.

Parameters:
- WIDTH, 8, unsigned width of in_a, in_b and in_c.
- MULT_STAGES, 1, number of register stages after the multiplier. Legal range 1..4.
- ACC_WIDTH, 2*WIDTH+8, width of the accumulator and out_data. Must be >= 2*WIDTH+1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  pipeline can accept a beat this cycle.
- in_a  in  WIDTH  addend a.
- in_b  in  WIDTH  addend b.
- in_c  in  WIDTH  multiplicand c.
- in_mode  in  2  operation mode:
  - 00: product only.
  - 01: acc += product.
  - 10: acc = product (load).
  - 11: treated as 00.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACC_WIDTH  result (zero-extended product, or updated accumulator).
- out_sum  out  WIDTH+1  a+b of the same beat, aligned with out_data.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset:
  - out_valid=0, out_data=0, out_sum=0.
  - Accumulator=0.
  - All internal valid bits=0.
  - All data registers=0.
  - Reset has priority over every other action.
  - Reset mid-operation discards all in-flight beats.
- Global enable: en = !out_valid || out_ready.
  - in_ready = en, purely combinational from out_valid and out_ready.
  - A beat is accepted when in_valid && in_ready.
- Stall: when en=0, every stage register, valid bit and the accumulator hold.
  - out_data, out_sum and out_valid stay stable until accepted.
- Advance: when en=1, all stages shift one position.
  - Valid bits propagate, so bubbles travel as valid=0.
  - Data registers of bubbles are don't-care.
- Stage 1: registers a, b, c and mode.
- Stage 2: registers sum = a+b as WIDTH+1 bits (no overflow loss), plus c and mode.
- Multiplier:
  - Unsigned product = sum*c, 2*WIDTH+1 bits.
  - Registered MULT_STAGES times.
  - sum and mode are delayed alongside it.
- Output stage: captures the final multiplier stage when en=1.
  - out_valid <= final-stage valid.
  - If that valid=1:
    - mode 00/11: out_data = zero-extended product; accumulator unchanged.
    - mode 01: acc <= acc + product, wrapping modulo 2^ACC_WIDTH; out_data = new acc value.
    - mode 10: acc <= product; out_data = product.
  - The accumulator updates only on a valid beat entering the output stage, exactly once per beat, including under backpressure.
- Latency: 3+MULT_STAGES cycles from the accept edge to out_valid=1 when not stalled.
  - Default configuration: 4 cycles.
- Throughput: 1 beat/cycle while out_ready=1.
- Boundaries:
  - Simultaneous out-accept and in-accept in the same cycle is legal, with no lost or duplicated beat.
  - in_valid=1 while in_ready=0: the beat is not taken. The producer must hold it.
  - All-ones inputs: sum=2^(WIDTH+1)-2, product exact.
  - Accumulator overflow wraps silently.

Test Plan:
1. Reset then single beat (WIDTH=8, MULT_STAGES=1): a=3, b=4, c=5, mode 00 -> out_valid 4 cycles after accept, out_data=35, out_sum=7, acc=0.
2. Max values: a=255, b=255, c=255, mode 00 -> out_sum=510, out_data=130050, no truncation.
3. Accumulate chain: beats mode 10 (1,1,2), then 01 (2,3,4), then 01 (0,5,5) -> out_data 4, 24, 49.
4. Backpressure: stream 6 beats (a=i, b=0, c=1, i=1..6) with out_ready low for 3 cycles mid-stream.
   - out_data sequence must be exactly 1..6, with no drops or duplicates.
   - in_ready is low while stalled.
   - A mode-01 beat held during the stall adds once.
5. Full throughput: 20 back-to-back beats with out_ready=1.
   - in_ready stays 1.
   - One result per cycle after the 4-cycle fill.
6. Reset mid-stream: assert rst with 3 beats in flight.
   - The next cycle has out_valid=0 and acc=0.
   - No stale beat emerges afterwards.
   - Next mode-01 beat (1,1,3) -> out_data=6.

Source files
------------

// File: rtl/add_mult_pipe.sv
// Elastic (a+b)*c pipeline with optional accumulate. A single global enable
// stalls every stage when the output register is full and not being drained.
module add_mult_pipe #(
  parameter int WIDTH       = 8,
  parameter int MULT_STAGES = 1,
  parameter int ACC_WIDTH   = 2*WIDTH+8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [WIDTH-1:0]     in_c,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [WIDTH:0]       out_sum
);
  localparam int PW = 2*WIDTH+1;

  logic                 w_en;
  logic                 r_out_valid;
  logic [ACC_WIDTH-1:0] r_out_data;
  logic [WIDTH:0]       r_out_sum;
  logic [ACC_WIDTH-1:0] r_acc;

  assign w_en      = !r_out_valid || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sum   = r_out_sum;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a, r_s1_b, r_s1_c;
  logic [1:0]       r_s1_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_c     <= '0;
      r_s1_mode  <= '0;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s1_a     <= in_a;
      r_s1_b     <= in_b;
      r_s1_c     <= in_c;
      r_s1_mode  <= in_mode;
    end
  end

  logic             r_s2_valid;
  logic [WIDTH:0]   r_s2_sum;
  logic [WIDTH-1:0] r_s2_c;
  logic [1:0]       r_s2_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_sum   <= '0;
      r_s2_c     <= '0;
      r_s2_mode  <= '0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      r_s2_sum   <= {1'b0, r_s1_a} + {1'b0, r_s1_b};
      r_s2_c     <= r_s1_c;
      r_s2_mode  <= r_s1_mode;
    end
  end

  logic [PW-1:0] w_prod;
  assign w_prod = PW'(r_s2_sum) * PW'(r_s2_c);

  // Multiplier delay line; each stage's input is the previous stage's output.
  logic             r_m_valid [MULT_STAGES];
  logic [PW-1:0]    r_m_prod  [MULT_STAGES];
  logic [WIDTH:0]   r_m_sum   [MULT_STAGES];
  logic [1:0]       r_m_mode  [MULT_STAGES];
  logic             w_m_valid [MULT_STAGES];
  logic [PW-1:0]    w_m_prod  [MULT_STAGES];
  logic [WIDTH:0]   w_m_sum   [MULT_STAGES];
  logic [1:0]       w_m_mode  [MULT_STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < MULT_STAGES; gi++) begin : g_mult
      if (gi == 0) begin : g_first
        assign w_m_valid[gi] = r_s2_valid;
        assign w_m_prod[gi]  = w_prod;
        assign w_m_sum[gi]   = r_s2_sum;
        assign w_m_mode[gi]  = r_s2_mode;
      end else begin : g_next
        assign w_m_valid[gi] = r_m_valid[gi-1];
        assign w_m_prod[gi]  = r_m_prod[gi-1];
        assign w_m_sum[gi]   = r_m_sum[gi-1];
        assign w_m_mode[gi]  = r_m_mode[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < MULT_STAGES; i++) begin
      if (rst) begin
        r_m_valid[i] <= 1'b0;
        r_m_prod[i]  <= '0;
        r_m_sum[i]   <= '0;
        r_m_mode[i]  <= '0;
      end else if (w_en) begin
        r_m_valid[i] <= w_m_valid[i];
        r_m_prod[i]  <= w_m_prod[i];
        r_m_sum[i]   <= w_m_sum[i];
        r_m_mode[i]  <= w_m_mode[i];
      end
    end
  end

  logic                 w_f_valid;
  logic [1:0]           w_f_mode;
  logic [ACC_WIDTH-1:0] w_f_ext;
  logic [ACC_WIDTH-1:0] w_acc_add;

  assign w_f_valid = r_m_valid[MULT_STAGES-1];
  assign w_f_mode  = r_m_mode[MULT_STAGES-1];
  assign w_f_ext   = ACC_WIDTH'(r_m_prod[MULT_STAGES-1]);
  assign w_acc_add = r_acc + w_f_ext;

  // Accumulator moves only when a valid beat enters the output register,
  // so a beat held during a stall is applied exactly once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sum   <= '0;
      r_acc       <= '0;
    end else if (w_en) begin
      r_out_valid <= w_f_valid;
      if (w_f_valid) begin
        r_out_sum <= r_m_sum[MULT_STAGES-1];
        case (w_f_mode)
          2'b01: begin
            r_acc      <= w_acc_add;
            r_out_data <= w_acc_add;
          end
          2'b10: begin
            r_acc      <= w_f_ext;
            r_out_data <= w_f_ext;
          end
          default: r_out_data <= w_f_ext;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_add_mult_pipe.sv
// Scoreboard bench for add_mult_pipe: a model computes each accepted beat's
// result at accept time; a monitor pops and compares on every output transfer.
module tb_add_mult_pipe;
  localparam int W  = 8;
  localparam int MS = 1;
  localparam int AW = 2*W+8;

  logic          clk, rst;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_a, in_b, in_c;
  logic [1:0]    in_mode;
  logic          out_valid, out_ready;
  logic [AW-1:0] out_data;
  logic [W:0]    out_sum;

  add_mult_pipe #(.WIDTH(W), .MULT_STAGES(MS), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sum(out_sum)
  );

  typedef struct {
    logic [AW-1:0] data;
    logic [W:0]    sum;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] m_acc;
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            stall_from = -1;
  int            stall_to = -1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Consumer: out_ready low while cyc is inside the requested stall window.
  initial begin
    out_ready = 1;
    forever begin
      @(negedge clk);
      cyc++;
      out_ready = !(cyc >= stall_from && cyc < stall_to);
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
        if (out_valid && out_ready) begin
          $display("out data=%0d sum=%0d", out_data, out_sum);
          if (sb.size() == 0) chk("spurious_out", 1, 0);
          else begin
            e = sb.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_sum", out_sum, e.sum);
          end
        end
      end
    end
  end

  task automatic model_push(input logic [W-1:0] a, b, c, input logic [1:0] m);
    exp_t          e;
    logic [W:0]    s;
    logic [AW-1:0] p;
    s = {1'b0, a} + {1'b0, b};
    p = AW'(s) * AW'(c);
    case (m)
      2'b01:   begin m_acc = m_acc + p; e.data = m_acc; end
      2'b10:   begin m_acc = p; e.data = p; end
      default: e.data = p;
    endcase
    e.sum = s;
    sb.push_back(e);
  endtask

  task automatic send(input logic [W-1:0] a, b, c, input logic [1:0] m, input bit must);
    int   tries = 0;
    logic took = 0;
    @(negedge clk);
    in_a = a; in_b = b; in_c = c; in_mode = m; in_valid = 1;
    while (!took && tries < 60) begin
      #1;
      if (must) chk("tput_in_ready", in_ready, 1);
      if (in_ready) begin
        took = 1;
        $display("in  a=%0d b=%0d c=%0d mode=%0d", a, b, c, m);
        model_push(a, b, c, m);
        @(posedge clk);
      end else begin
        tries++;
        @(negedge clk);
      end
    end
    if (!took) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 0;
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    forever begin
      @(negedge clk);
      in_valid = 0;
      #3;
      if (out_valid || lat > 20) break;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      in_valid = 0;
      n++;
    end
    idle(2);
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    int lat;
    rst = 1; in_valid = 0; in_a = 0; in_b = 0; in_c = 0; in_mode = 0;
    m_acc = 0;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 0;

    // single beat and latency
    send(3, 4, 5, 2'b00, 0);
    wait_out(lat);
    chk("t1_latency", lat, 3 + MS);
    chk("t1_data", out_data, 35);
    chk("t1_sum", out_sum, 7);
    drain("t1_drain");

    // all-ones inputs
    send(255, 255, 255, 2'b00, 0);
    wait_out(lat);
    chk("t2_latency", lat, 3 + MS);
    chk("t2_data", out_data, 130050);
    chk("t2_sum", out_sum, 510);
    drain("t2_drain");

    // accumulate chain: 4, 24, 49 (mode 11 behaves as product-only)
    send(1, 1, 2, 2'b10, 0);
    send(2, 3, 4, 2'b01, 0);
    send(0, 5, 5, 2'b01, 0);
    send(2, 2, 2, 2'b11, 0);
    drain("t3_drain");

    // backpressure, product-only then accumulate
    stall_from = cyc + 5; stall_to = cyc + 8;
    for (int i = 1; i <= 6; i++) send(W'(i), 0, 1, 2'b00, 0);
    drain("t4_drain");
    send(0, 0, 0, 2'b10, 0);
    stall_from = cyc + 5; stall_to = cyc + 8;
    for (int i = 1; i <= 6; i++) send(W'(i), 0, 1, 2'b01, 0);
    drain("t4b_drain");

    // full throughput
    fork
      begin
        for (int i = 0; i < 20; i++) send(W'(i * 13), W'(i + 1), W'(i % 7 + 1), 2'(i % 3), 1);
        idle(1);
      end
      begin
        int n = 0;
        do begin
          @(negedge clk);
          #3;
          n++;
        end while (!out_valid && n < 20);
        chk("tput_fill", out_valid, 1);
        for (int i = 0; i < 20; i++) begin
          chk("tput_out_valid", out_valid, 1);
          @(negedge clk);
          #3;
        end
      end
    join
    drain("t5_drain");

    // reset with beats in flight
    send(9, 9, 9, 2'b01, 0);
    send(8, 8, 8, 2'b01, 0);
    send(7, 7, 7, 2'b01, 0);
    @(negedge clk);
    in_valid = 0;
    rst = 1;
    sb.delete();
    m_acc = 0;
    @(negedge clk);
    #3;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_data", out_data, 0);
    rst = 0;
    idle(8);
    send(1, 1, 3, 2'b01, 0);
    wait_out(lat);
    chk("t6_data", out_data, 6);
    drain("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
